user_sobel_stream: RTL and testbench

Streaming, parametrised 3x3 Sobel edge detector on an OBI subordinate port in the user domain. Software writes pixels in raster order; the block keeps two line buffers and a 3x3 sliding window, and computes one result per valid window position through a two-stage pipeline. Results are pushed into a result FIFO that software drains over OBI. Pixel width, maximum row width, FIFO depth and output mode (magnitude, |Gx|, |Gy|, threshold) are configurable.

---
 rtl/user_sobel_pkg.sv | 42 ++++
 rtl/user_sobel_core.sv | 103 ++++++++++
 rtl/user_sobel_stream.sv | 166 ++++++++++++++++
 tb/tb_user_sobel_stream.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_sobel_pkg.sv
// user_sobel_pkg: register map, CTRL fields, output modes and bus types for the Sobel stream block
package user_sobel_pkg;

   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [0:0]  aid;
   } sobel_obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } sobel_obi_rsp_t;

   localparam logic [2:0] RegCtrl   = 3'd0;
   localparam logic [2:0] RegWidth  = 3'd1;
   localparam logic [2:0] RegPixel  = 3'd2;
   localparam logic [2:0] RegStatus = 3'd3;
   localparam logic [2:0] RegResult = 3'd4;

   typedef enum logic [1:0] {MAG, GX, GY, THRESH} sobel_mode_e;

   localparam int unsigned CtrlEnBit     = 0;
   localparam int unsigned CtrlModeLsb   = 1;
   localparam int unsigned CtrlClearBit  = 3;
   localparam int unsigned CtrlThreshLsb = 16;

endpackage

// File: rtl/user_sobel_core.sv
// user_sobel_core: line buffers, 3x3 window and two-stage Sobel pipeline
module user_sobel_core import user_sobel_pkg::*; #(
   parameter int unsigned PixelWidth = 8,
   parameter int unsigned MaxWidth   = 64,
   localparam int unsigned CntW      = $clog2(MaxWidth),
   localparam int unsigned WW        = $clog2(MaxWidth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  pix_valid_i,
   input  logic [PixelWidth-1:0] pix_i,
   input  logic [WW-1:0]         width_i,
   input  sobel_mode_e           mode_i,
   input  logic [PixelWidth-1:0] thresh_i,
   output logic                  res_valid_o,
   output logic [PixelWidth-1:0] res_o,
   output logic [1:0]            inflight_o
);
   localparam int unsigned GW = PixelWidth + 3;
   localparam int unsigned AW = PixelWidth + 2;

   logic [CntW-1:0]       col_q;
   logic [1:0]            row_q;
   logic [PixelWidth-1:0] lb0 [MaxWidth];
   logic [PixelWidth-1:0] lb1 [MaxWidth];
   logic [PixelWidth-1:0] win_q [3][3];
   logic                  win_valid_q, s1_valid_q, last_col;
   logic signed [GW-1:0]  w [3][3];
   logic signed [GW-1:0]  gx_d, gy_d, gx_q, gy_q;
   logic [AW-1:0]         ax, ay;
   logic [GW-1:0]         sum;
   logic [PixelWidth-1:0] mag, sx, sy;

   assign last_col = WW'(col_q) == width_i - WW'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '{default: '0};
         win_valid_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         gx_q        <= '0;
         gy_q        <= '0;
      end else if (clear_i) begin
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '{default: '0};
         win_valid_q <= 1'b0;
         s1_valid_q  <= 1'b0;
      end else begin
         win_valid_q <= pix_valid_i && row_q == 2'd2 && col_q >= CntW'(2);
         s1_valid_q  <= win_valid_q;
         gx_q        <= gx_d;
         gy_q        <= gy_d;
         if (pix_valid_i) begin
            col_q <= last_col ? '0 : col_q + 1'b1;
            if (last_col && row_q != 2'd2) row_q <= row_q + 1'b1;
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1[col_q];
            win_q[1][2] <= lb0[col_q];
            win_q[2][2] <= pix_i;
         end
      end
   end

   // line buffer contents need no reset; only the counters decide what is valid
   always_ff @(posedge clk_i) begin
      if (pix_valid_i && !clear_i) begin
         lb1[col_q] <= lb0[col_q];
         lb0[col_q] <= pix_i;
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[r][c] = signed'(GW'(win_q[r][c]));
   end

   assign gx_d = (w[0][2] + (w[1][2] <<< 1) + w[2][2]) - (w[0][0] + (w[1][0] <<< 1) + w[2][0]);
   assign gy_d = (w[2][0] + (w[2][1] <<< 1) + w[2][2]) - (w[0][0] + (w[0][1] <<< 1) + w[0][2]);

   assign ax  = AW'(gx_q[GW-1] ? -gx_q : gx_q);
   assign ay  = AW'(gy_q[GW-1] ? -gy_q : gy_q);
   assign sum = GW'(ax) + GW'(ay);
   assign mag = |sum[GW-1:PixelWidth] ? '1 : sum[PixelWidth-1:0];
   assign sx  = |ax[AW-1:PixelWidth] ? '1 : ax[PixelWidth-1:0];
   assign sy  = |ay[AW-1:PixelWidth] ? '1 : ay[PixelWidth-1:0];

   assign res_o = mode_i == MAG ? mag :
                  mode_i == GX  ? sx  :
                  mode_i == GY  ? sy  :
                  (mag >= thresh_i ? '1 : '0);

   assign res_valid_o = s1_valid_q;
   assign inflight_o  = {1'b0, win_valid_q} + {1'b0, s1_valid_q};

endmodule

// File: rtl/user_sobel_stream.sv
// user_sobel_stream: OBI register front end, config/sticky state and result FIFO around the Sobel core
module user_sobel_stream import user_sobel_pkg::*; #(
   parameter obi_cfg_t    ObiCfg     = ObiDefaultConfig,
   parameter type         obi_req_t  = sobel_obi_req_t,
   parameter type         obi_rsp_t  = sobel_obi_rsp_t,
   parameter int unsigned PixelWidth = 8,
   parameter int unsigned MaxWidth   = 64,
   parameter int unsigned FifoDepth  = 8
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  obi_req_t obi_req_i,
   output obi_rsp_t obi_rsp_o
);
   localparam int unsigned DW = ObiCfg.DataWidth;
   localparam int unsigned WW = $clog2(MaxWidth + 1);
   localparam int unsigned PW = $clog2(FifoDepth);
   localparam int unsigned CW = PW + 1;

   logic                        q_valid, q_we;
   logic [2:0]                  q_idx;
   logic [DW-1:0]               q_wdata;
   logic [ObiCfg.IdWidth-1:0]   q_aid;
   logic                        enable_q, ovf_q, unf_q;
   sobel_mode_e                 mode_q;
   logic [PixelWidth-1:0]       thresh_q;
   logic [WW-1:0]               width_q;
   logic                        wr, rd, accept, pix_valid, clear, pop, push;
   logic                        res_valid, fifo_empty, fifo_full;
   logic [PixelWidth-1:0]       res, fifo_out;
   logic [1:0]                  inflight;
   logic [PixelWidth-1:0]       mem [FifoDepth];
   logic [PW-1:0]               wptr, rptr;
   logic [CW-1:0]               fifo_cnt;
   logic [DW-1:0]               ctrl_rd, status_rd, rdata;
   logic                        err;
   logic                        unused_bits;

   assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[1:0], obi_req_i.addr[31:5]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_valid <= 1'b0;
         q_we    <= 1'b0;
         q_idx   <= '0;
         q_wdata <= '0;
         q_aid   <= '0;
      end else begin
         q_valid <= obi_req_i.req;
         if (obi_req_i.req) begin
            q_we    <= obi_req_i.we;
            q_idx   <= obi_req_i.addr[4:2];
            q_wdata <= obi_req_i.wdata;
            q_aid   <= obi_req_i.aid;
         end
      end
   end

   assign wr         = q_valid && q_we;
   assign rd         = q_valid && !q_we;
   assign fifo_empty = fifo_cnt == '0;
   assign fifo_full  = fifo_cnt == CW'(FifoDepth);
   // results still in the pipeline reserve FIFO space so a push never finds it full
   assign accept     = enable_q && (32'(fifo_cnt) + 32'(inflight) < FifoDepth);
   assign pix_valid  = wr && q_idx == RegPixel && accept;
   assign clear      = wr && ((q_idx == RegCtrl && q_wdata[CtrlClearBit]) || q_idx == RegWidth);
   assign pop        = rd && q_idx == RegResult && !fifo_empty;
   assign push       = res_valid && !clear && !fifo_full;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enable_q <= 1'b0;
         mode_q   <= MAG;
         thresh_q <= '0;
         width_q  <= WW'(MaxWidth);
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         if (wr && q_idx == RegCtrl) begin
            enable_q <= q_wdata[CtrlEnBit];
            mode_q   <= sobel_mode_e'(q_wdata[CtrlModeLsb +: 2]);
            thresh_q <= q_wdata[CtrlThreshLsb +: PixelWidth];
         end
         if (wr && q_idx == RegWidth)
            width_q <= q_wdata < 3 ? WW'(3) : q_wdata > MaxWidth ? WW'(MaxWidth) : WW'(q_wdata);
         if (clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            if (wr && q_idx == RegPixel && enable_q && !accept) ovf_q <= 1'b1;
            else if (wr && q_idx == RegStatus && q_wdata[2]) ovf_q <= 1'b0;
            if (rd && q_idx == RegResult && fifo_empty) unf_q <= 1'b1;
            else if (wr && q_idx == RegStatus && q_wdata[3]) unf_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr     <= '0;
         rptr     <= '0;
         fifo_cnt <= '0;
      end else if (clear) begin
         wptr     <= '0;
         rptr     <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= res;
   end

   assign fifo_out  = mem[rptr];
   assign ctrl_rd   = (DW'(thresh_q) << CtrlThreshLsb) | (DW'(mode_q) << CtrlModeLsb) | DW'(enable_q);
   assign status_rd = (DW'(fifo_cnt) << 16) | DW'({unf_q, ovf_q, fifo_full, fifo_empty});

   always_comb begin
      rdata = '0;
      err   = 1'b0;
      if (q_valid) begin
         case (q_idx)
            RegCtrl:   rdata = q_we ? '0 : ctrl_rd;
            RegWidth:  rdata = q_we ? '0 : DW'(width_q);
            RegPixel:  err = q_we ? !accept : 1'b1;
            RegStatus: rdata = q_we ? '0 : status_rd;
            RegResult: begin
               err   = q_we || fifo_empty;
               rdata = (q_we || fifo_empty) ? '0 : DW'(fifo_out);
            end
            default: begin
               rdata = '1;
               err   = 1'b1;
            end
         endcase
      end
   end

   assign obi_rsp_o.gnt    = obi_req_i.req;
   assign obi_rsp_o.rvalid = q_valid;
   assign obi_rsp_o.rdata  = rdata;
   assign obi_rsp_o.rid    = q_aid;
   assign obi_rsp_o.err    = err;

   user_sobel_core #(
      .PixelWidth(PixelWidth),
      .MaxWidth  (MaxWidth)
   ) u_core (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear),
      .pix_valid_i(pix_valid),
      .pix_i      (q_wdata[PixelWidth-1:0]),
      .width_i    (width_q),
      .mode_i     (mode_q),
      .thresh_i   (thresh_q),
      .res_valid_o(res_valid),
      .res_o      (res),
      .inflight_o (inflight)
   );

endmodule

// File: tb/tb_user_sobel_stream.sv
// tb_user_sobel_stream: randomized scoreboard bench with a frame-level Sobel reference model
module tb_user_sobel_stream;
   import user_sobel_pkg::*;

   localparam int unsigned Depth = 8;
   localparam int unsigned MaxW  = 64;

   logic           clk, rst_n;
   sobel_obi_req_t req;
   sobel_obi_rsp_t rsp;

   user_sobel_stream dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .obi_req_i(req),
      .obi_rsp_o(rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      bit          chk;
      logic        id;
      int unsigned idx;
   } exp_t;

   typedef struct {
      int unsigned val;
      int unsigned g;
   } res_t;

   exp_t        sb[$];
   res_t        rq[$];
   int unsigned frame[$];
   int unsigned cyc, total, bad;
   int unsigned m_en, m_mode, m_thr, m_w;
   bit          m_ovf, m_unf, done;

   // results are readable once three cycles have passed since the pixel's grant
   function automatic int unsigned landed();
      int unsigned n = 0;
      foreach (rq[i]) if (rq[i].g + 3 <= cyc) n++;
      return n;
   endfunction

   function automatic int unsigned sat(int v);
      return v > 255 ? 255 : v;
   endfunction

   function automatic int unsigned sobel_ref(int unsigned n);
      int r = n / m_w;
      int c = n % m_w;
      int p[3][3];
      int gx, gy, ax, ay, mag;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = frame[(r - 2 + i) * m_w + (c - 2 + j)];
      gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
      gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
      ax  = gx < 0 ? -gx : gx;
      ay  = gy < 0 ? -gy : gy;
      mag = sat(ax + ay);
      case (m_mode)
         0: return mag;
         1: return sat(ax);
         2: return sat(ay);
         default: return mag >= int'(m_thr) ? 255 : 0;
      endcase
   endfunction

   function automatic void model_clear();
      frame.delete();
      rq.delete();
      m_ovf = 0;
      m_unf = 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(int n);
      req.req = 1'b0;
      repeat (n) step();
   endtask

   task automatic issue(bit we, int unsigned idx, logic [31:0] wd);
      exp_t        e;
      int unsigned n, cnt;
      e.rdata = 32'h0;
      e.err   = 1'b0;
      e.chk   = !we;
      e.id    = 1'($urandom);
      e.idx   = idx;
      case (idx)
         0: if (we) begin
               m_en   = wd[0];
               m_mode = wd[2:1];
               m_thr  = wd[23:16];
               if (wd[3]) model_clear();
            end else e.rdata = m_en | (m_mode << 1) | (m_thr << 16);
         1: if (we) begin
               m_w = wd < 3 ? 3 : wd > MaxW ? MaxW : wd;
               model_clear();
            end else e.rdata = m_w;
         2: if (!we) e.err = 1'b1;
            else if (m_en != 0 && rq.size() < Depth) begin
               n = frame.size();
               frame.push_back(wd[7:0]);
               if (n / m_w >= 2 && n % m_w >= 2) rq.push_back('{val: sobel_ref(n), g: cyc});
            end else begin
               e.err = 1'b1;
               if (m_en != 0) m_ovf = 1;
            end
         3: if (we) begin
               if (wd[2]) m_ovf = 0;
               if (wd[3]) m_unf = 0;
            end else begin
               cnt     = landed();
               e.rdata = (cnt << 16) | (m_unf << 3) | (m_ovf << 2) | ((cnt == Depth) << 1) | (cnt == 0);
            end
         4: if (we) e.err = 1'b1;
            else if (landed() > 0) e.rdata = rq.pop_front().val;
            else begin
               e.err = 1'b1;
               m_unf = 1;
            end
         default: begin
            e.err   = 1'b1;
            e.rdata = 32'hFFFF_FFFF;
         end
      endcase
      sb.push_back(e);
      req.req   = 1'b1;
      req.we    = we;
      req.be    = 4'hF;
      req.addr  = idx << 2;
      req.wdata = wd;
      req.aid   = e.id;
      step();
   endtask

   task automatic frame3(int unsigned a, int unsigned b, int unsigned c, int rows);
      for (int r = 0; r < rows; r++) begin
         issue(1, 2, a);
         issue(1, 2, b);
         issue(1, 2, c);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         total++;
         if (rsp.rvalid !== 1'b0 || rsp.rdata !== 32'h0 || rsp.rid !== 1'b0 || rsp.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got rvalid=%b rdata=%h rid=%b err=%b, want all 0", rsp.rvalid, rsp.rdata, rsp.rid, rsp.err);
         end
      end else if (done) begin
         total++;
         if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_rsp: %0d responses never arrived, want 0", sb.size());
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end else if (rsp.rvalid) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rsp: got rdata=%h err=%b with nothing outstanding", rsp.rdata, rsp.err);
         end else begin
            e = sb.pop_front();
            if (rsp.err !== e.err || rsp.rid !== e.id || (e.chk && rsp.rdata !== e.rdata)) begin
               bad++;
               $display("FAIL rsp idx=%0d: got rdata=%h err=%b rid=%b, want rdata=%h err=%b rid=%b",
                        e.idx, rsp.rdata, rsp.err, rsp.rid, e.rdata, e.err, e.id);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end

   initial begin
      int unsigned p, v, n;
      req   = '0;
      rst_n = 1'b0;
      cyc   = 0;
      done  = 0;
      m_en  = 0;
      m_mode = 0;
      m_thr = 0;
      m_w   = MaxW;
      m_ovf = 0;
      m_unf = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      issue(0, 0, 0);
      issue(0, 1, 0);
      issue(0, 3, 0);
      issue(0, 5, 0);
      issue(1, 6, 32'h1234);
      issue(0, 7, 0);
      // saturated vertical edge, read exactly three cycles after the last pixel
      issue(1, 0, 32'h1);
      issue(1, 1, 3);
      frame3(0, 0, 255, 3);
      idle(2);
      issue(0, 4, 0);
      issue(0, 4, 0);
      issue(0, 3, 0);
      // flat image
      issue(1, 1, 4);
      for (int i = 0; i < 12; i++) issue(1, 2, 100);
      idle(3);
      issue(0, 3, 0);
      issue(0, 4, 0);
      issue(0, 3, 0);
      issue(0, 4, 0);
      issue(0, 3, 0);
      // threshold mode on a 0|60 edge
      issue(1, 1, 4);
      issue(1, 0, (50 << 16) | (3 << 1) | 1);
      for (int r = 0; r < 3; r++) begin
         issue(1, 2, 0); issue(1, 2, 0); issue(1, 2, 60); issue(1, 2, 60);
      end
      idle(3);
      issue(0, 4, 0);
      issue(0, 4, 0);
      issue(1, 1, 4);
      issue(1, 0, (250 << 16) | (3 << 1) | 1);
      for (int r = 0; r < 3; r++) begin
         issue(1, 2, 0); issue(1, 2, 0); issue(1, 2, 60); issue(1, 2, 60);
      end
      idle(3);
      issue(0, 4, 0);
      issue(0, 4, 0);
      issue(0, 0, 0);
      // width clamping
      issue(1, 1, 0);
      issue(0, 1, 0);
      issue(1, 1, 1000);
      issue(0, 1, 0);
      // overflow: twelve rows of width 3 give ten windows
      issue(1, 0, 32'h1);
      issue(1, 1, 3);
      for (int i = 0; i < 36; i++) issue(1, 2, $urandom_range(0, 255));
      idle(3);
      issue(0, 3, 0);
      issue(1, 3, 32'h4);
      issue(0, 3, 0);
      repeat (9) issue(0, 4, 0);
      issue(1, 3, 32'h8);
      issue(0, 3, 0);
      // disabled writes are dropped without raising overflow
      issue(1, 0, 32'h0);
      issue(1, 2, 10);
      issue(0, 3, 0);
      issue(0, 2, 0);
      issue(1, 4, 0);
      // clear while results are in flight, then a fresh frame
      issue(1, 0, 32'h1);
      issue(1, 1, 3);
      frame3(0, 0, 255, 3);
      issue(1, 0, 32'h9);
      idle(4);
      issue(0, 3, 0);
      frame3(200, 10, 0, 3);
      idle(3);
      issue(0, 4, 0);
      issue(0, 4, 0);
      // randomized rounds
      for (int round = 0; round < 6; round++) begin
         idle(4);
         issue(1, 1, $urandom_range(3, 8));
         issue(1, 0, ($urandom_range(0, 255) << 16) | ($urandom_range(0, 3) << 1) | 1);
         for (int k = 0; k < 90; k++) begin
            p = $urandom_range(0, 99);
            if (p < 65) begin
               v = $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : ($urandom_range(0, 1) ? 255 : 0);
               issue(1, 2, v);
            end else if (p < 82) issue(0, 4, 0);
            else if (p < 90) issue(0, 3, 0);
            else if (p < 93) issue(1, 3, $urandom);
            else if (p < 96) idle($urandom_range(1, 3));
            else begin
               n = $urandom_range(0, 5);
               if (n < 2) issue(0, n, 0);
               else if (n == 2) issue(0, 2, 0);
               else if (n == 3) issue(1, 4, 0);
               else issue(n[0], $urandom_range(5, 7), $urandom);
            end
         end
         idle(4);
         n = rq.size();
         repeat (n + 1) issue(0, 4, 0);
         issue(0, 3, 0);
      end
      idle(4);
      done = 1;
   end

endmodule
